// File: rtl/prog_loader.sv
// prog_loader: boot loader that assembles a byte-stream frame into instruction memory
// and releases the core from reset once the checksum has been verified.
module prog_loader #(
   parameter int AW   = 8,
   parameter int MAXW = 256
) (
   input  logic          clk,
   input  logic          rstd,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic [AW-1:0] pc,
   output logic [31:0]   ins,
   output logic          cpu_rstd,
   output logic          done,
   output logic          err,
   output logic [15:0]   words
);
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;
   state_t state, state_nx;
   logic [7:0]    n_hi, csum;
   logic [AW-1:0] waddr;
   logic [1:0]    bidx;
   logic [23:0]   shreg;
   logic [31:0]   mem [2**AW];
   logic          acc, last_word, hdr_bad, word_end;
   logic [15:0]   n_full;
   assign acc       = in_valid && in_ready;
   assign n_full    = {n_hi, in_data};
   assign hdr_bad   = n_full == 16'd0 || n_full > 16'(MAXW);
   assign last_word = 16'(waddr) == words - 16'd1;
   assign word_end  = bidx == 2'd3;
   always_ff @(posedge clk or negedge rstd)
      if (!rstd) state <= HDR_HI;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (acc)
         case (state)
            HDR_HI:  state_nx = HDR_LO;
            HDR_LO:  state_nx = hdr_bad ? ERR : DATA;
            DATA:    state_nx = word_end && last_word ? CSUM : DATA;
            CSUM:    state_nx = in_data == csum ? DONE : ERR;
            default: state_nx = state;
         endcase
   end
   always_comb begin
      in_ready = state != DONE && state != ERR;
      done     = state == DONE;
      cpu_rstd = state == DONE;
      err      = state == ERR;
   end
   always_ff @(posedge clk or negedge rstd)
      if (!rstd) begin
         n_hi  <= '0;
         words <= '0;
         waddr <= '0;
         bidx  <= '0;
         shreg <= '0;
         csum  <= '0;
      end else if (acc)
         case (state)
            HDR_HI: n_hi <= in_data;
            HDR_LO: begin
               words <= n_full;
               waddr <= '0;
               bidx  <= '0;
               csum  <= '0;
            end
            DATA: begin
               shreg <= {shreg[15:0], in_data};
               csum  <= csum ^ in_data;
               bidx  <= bidx + 2'd1;
               if (word_end && !last_word) waddr <= waddr + AW'(1);
            end
            default: ;
         endcase
   // Memory survives reset so a reloaded core sees the old image until overwritten.
   always_ff @(posedge clk)
      if (acc && state == DATA && word_end) mem[waddr] <= {shreg, in_data};
   assign ins = 16'(pc) < words ? mem[pc] : 32'h0;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vector table plus hand-written multi-cycle sequences for prog_loader.
`timescale 1ns/1ps
module tb_prog_loader;
   logic        clk = 0, rstd = 0, in_valid = 0;
   logic [7:0]  in_data = 0, pc = 0;
   logic        in_ready, cpu_rstd, done, err;
   logic [31:0] ins;
   logic [15:0] words;
   int n_run = 0, n_fail = 0;

   prog_loader dut (.clk(clk), .rstd(rstd), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .pc(pc), .ins(ins), .cpu_rstd(cpu_rstd), .done(done),
      .err(err), .words(words));

   always #5 clk = ~clk;

   // XOR of the eight data bytes 12 34 56 78 9A BC DE F0 is 00.
   logic [7:0] good [11] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic [7:0]  p;
      logic        r, dn, e, c;
      logic [15:0] w;
      logic [31:0] i;
   } vec_t;
   vec_t tbl [15];

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_run++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d);
   endtask

   task automatic do_reset();
      rstd = 0;
      @(negedge clk);
      @(negedge clk);
      rstd = 1;
      @(posedge clk);
      #1;
      chk("reset_state", {in_ready, done, err, cpu_rstd, words}, {4'b1000, 16'd0});
   endtask

   // flags = {in_ready, done, err, cpu_rstd}
   function automatic logic [3:0] flags();
      return {in_ready, done, err, cpu_rstd};
   endfunction

   initial begin
      int nz;
      tbl[0]  = '{1'b1, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0};
      tbl[1]  = '{1'b1, 8'h02, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h0};
      tbl[2]  = '{1'b1, 8'h12, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h0};
      tbl[3]  = '{1'b1, 8'h34, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h0};
      tbl[4]  = '{1'b1, 8'h56, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h0};
      tbl[5]  = '{1'b0, 8'hFF, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h0};
      tbl[6]  = '{1'b1, 8'h78, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h12345678};
      tbl[7]  = '{1'b1, 8'h9A, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h12345678};
      tbl[8]  = '{1'b1, 8'hBC, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h12345678};
      tbl[9]  = '{1'b1, 8'hDE, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h12345678};
      tbl[10] = '{1'b1, 8'hF0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h9ABCDEF0};
      tbl[11] = '{1'b0, 8'h55, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 32'h9ABCDEF0};
      tbl[12] = '{1'b1, 8'h00, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 32'h9ABCDEF0};
      tbl[13] = '{1'b1, 8'hAA, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 32'h0};
      tbl[14] = '{1'b1, 8'hBB, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 32'h12345678};

      do_reset();
      for (int k = 0; k < 15; k++) begin
         pc = tbl[k].p;
         step(tbl[k].v, tbl[k].d);
         chk($sformatf("vec%0d", k), {flags(), words, ins},
             {tbl[k].r, tbl[k].dn, tbl[k].e, tbl[k].c, tbl[k].w, tbl[k].i});
      end

      // Bad checksum, then bytes offered in ERR are ignored
      do_reset();
      for (int k = 0; k < 10; k++) send(good[k]);
      send(8'h89);
      chk("badcsum", flags(), 4'b0010);
      repeat (3) send(8'h00);
      chk("badcsum_hold", {flags(), words}, {4'b0010, 16'd2});

      // Illegal headers
      do_reset();
      send(8'h00);
      chk("hdr0_first", flags(), 4'b1000);
      send(8'h00);
      chk("hdr0_err", {flags(), words}, {4'b0010, 16'd0});
      do_reset();
      send(8'h01);
      send(8'h01);
      chk("hdr257_err", {flags(), words}, {4'b0010, 16'd257});
      pc = 8'd0;
      #1 chk("hdr257_nowrite0", ins, 32'h12345678);
      pc = 8'd1;
      #1 chk("hdr257_nowrite1", ins, 32'h9ABCDEF0);

      // Good frame with random gaps
      do_reset();
      for (int k = 0; k < 10; k++) begin
         repeat ($urandom_range(0, 5)) step(1'b0, 8'hFF);
         send(good[k]);
      end
      repeat ($urandom_range(1, 5)) step(1'b0, 8'hFF);
      chk("gaps_before_last", flags(), 4'b1000);
      send(good[10]);
      chk("gaps_done", flags(), 4'b0101);
      pc = 8'd0;
      #1 chk("gaps_mem0", ins, 32'h12345678);
      pc = 8'd1;
      #1 chk("gaps_mem1", ins, 32'h9ABCDEF0);
      pc = 8'd2;
      #1 chk("gaps_mem2", ins, 32'h0);
      send(8'h00);
      chk("done_hold", {flags(), words}, {4'b0101, 16'd2});

      // Asynchronous reset mid-load
      do_reset();
      for (int k = 0; k < 6; k++) send(good[k]);
      #3 rstd = 0;
      #1 chk("midreset_outs", {cpu_rstd, done, words}, {2'b00, 16'd0});
      nz = 0;
      for (int p = 0; p < 256; p++) begin
         pc = p[7:0];
         #1 if (ins !== 32'h0) nz++;
      end
      chk("midreset_ins", nz, 0);
      @(negedge clk);
      rstd = 1;
      #1 chk("midreset_release", {flags(), words}, {4'b1000, 16'd0});
      for (int k = 0; k < 11; k++) send(good[k]);
      chk("reload_done", flags(), 4'b0101);
      pc = 8'd1;
      #1 chk("reload_mem1", ins, 32'h9ABCDEF0);

      // Full depth: word i = {4{i}}, checksum 00
      do_reset();
      send(8'h01);
      send(8'h00);
      for (int w = 0; w < 256; w++) repeat (4) send(w[7:0]);
      chk("full_csum_state", flags(), 4'b1000);
      send(8'h00);
      chk("full_done", {flags(), words}, {4'b0101, 16'd256});
      pc = 8'd255;
      #1 chk("full_mem255", ins, 32'hFFFFFFFF);
      pc = 8'd0;
      #1 chk("full_mem0", ins, 32'h00000000);
      pc = 8'd128;
      #1 chk("full_mem128", ins, 32'h80808080);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
